operand_reservation_station: RTL and testbench

Reservation station that sits directly upstream of the two operand collectors (type 0 and type 1). It accepts dispatched instructions with up to three source register indices and exports per-entry operand requests on the collectors' request vector. It snoops both collectors' RF buses to capture operand vectors by tag. Fully-collected instructions are handed to execution through a registered valid/ready issue port.

---
 rtl/operand_reservation_station_pkg.sv | 31 +++
 rtl/operand_reservation_station_prio_enc.sv | 20 ++
 rtl/operand_reservation_station.sv | 173 +++++++++++++++++
 tb/tb_operand_reservation_station.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_reservation_station_pkg.sv
// Shared types for the operand reservation station: register index/vector types,
// the per-entry record and the bus-match helper used by capture and dispatch bypass.
package operand_reservation_station_pkg;

    localparam int NUM_COLLECTORS = 2;
    localparam int GREG_IDX_W     = 6;
    localparam int VECTOR_W       = 32;

    typedef logic [GREG_IDX_W-1:0] GRegIdx_t;
    typedef logic [VECTOR_W-1:0]   Vector_t;

    typedef struct packed {
        logic           busy;
        GRegIdx_t [2:0] gIdx;
        logic [2:0]     used;
        logic [2:0]     gType;
        logic [2:0]     captured;
        Vector_t [2:0]  data;
    } RsEntry_t;

    // Only the bus owned by the operand's collector type may satisfy it
    function automatic logic busHit(
        input logic [NUM_COLLECTORS-1:0]     valid,
        input GRegIdx_t [NUM_COLLECTORS-1:0] tag,
        input GRegIdx_t                      gIdx,
        input logic                          gType
    );
        return valid[gType] && (tag[gType] == gIdx);
    endfunction

endpackage

// File: rtl/operand_reservation_station_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module rs_prio_enc #(
    parameter int Width = 16,
    parameter int IdxW  = $clog2(Width)
) (
    input  logic [Width-1:0] req,
    output logic [IdxW-1:0]  idx,
    output logic             found
);

    // Scan downwards so the lowest set bit is the last to win
    always_comb begin
        idx = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            idx = req[i] ? IdxW'(i) : idx;
        end
        found = |req;
    end

endmodule

// File: rtl/operand_reservation_station.sv
// Reservation station feeding the two operand collectors: holds dispatched
// instructions, snoops the RF buses for operands and issues through a registered port.
module operand_reservation_station
    import operand_reservation_station_pkg::*;
#(
    parameter int Entries = 16,
    parameter int OpWidth = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          dispValid,
    output logic                          dispReady,
    input  logic [OpWidth-1:0]            dispOp,
    input  GRegIdx_t [2:0]                dispGIdx,
    input  logic [2:0]                    dispGIdxValid,
    input  logic [2:0]                    dispGIdxType,
    output logic [Entries-1:0]            reqMaster,
    output GRegIdx_t [Entries-1:0][2:0]   reqGIdx,
    output logic [Entries-1:0][2:0]       reqGIdxValid,
    output logic [Entries-1:0][2:0]       reqGIdxType,
    input  logic [NUM_COLLECTORS-1:0]     RFBusValid,
    input  GRegIdx_t [NUM_COLLECTORS-1:0] RFBusTag,
    input  Vector_t [NUM_COLLECTORS-1:0]  RFBusData,
    output logic                          issueValid,
    input  logic                          issueReady,
    output logic [OpWidth-1:0]            issueOp,
    output Vector_t [2:0]                 issueData,
    output logic [2:0]                    issueOpValid,
    output logic [$clog2(Entries+1)-1:0]  freeCount
);

    localparam int IdxW = $clog2(Entries);
    localparam int CntW = $clog2(Entries + 1);

    RsEntry_t           entries_r     [Entries];
    RsEntry_t           entriesNext_s [Entries];
    logic [OpWidth-1:0] entryOp_r     [Entries];
    logic [2:0]         pend_s        [Entries];
    logic [2:0]         capHit_s      [Entries];
    RsEntry_t           dispEntry_s;
    logic [Entries-1:0] freeVec_s;
    logic [Entries-1:0] readyVec_s;
    logic [IdxW-1:0]    freeIdx_s;
    logic [IdxW-1:0]    readyIdx_s;
    logic               freeFound_s;
    logic               readyFound_s;
    logic               dispFire_s;
    logic               issueLoad_s;
    logic [CntW-1:0]    freeCount_r;
    logic               issueValid_r;
    logic [OpWidth-1:0] issueOp_r;
    Vector_t [2:0]      issueData_r;
    logic [2:0]         issueOpValid_r;

    rs_prio_enc #(.Width(Entries), .IdxW(IdxW)) u_freeEnc (
        .req   (freeVec_s),
        .idx   (freeIdx_s),
        .found (freeFound_s)
    );

    rs_prio_enc #(.Width(Entries), .IdxW(IdxW)) u_readyEnc (
        .req   (readyVec_s),
        .idx   (readyIdx_s),
        .found (readyFound_s)
    );

    assign dispReady    = (freeCount_r != CntW'(0));
    assign dispFire_s   = dispValid & dispReady & freeFound_s;
    assign issueLoad_s  = (~issueValid_r | issueReady) & readyFound_s;
    assign freeCount    = freeCount_r;
    assign issueValid   = issueValid_r;
    assign issueOp      = issueOp_r;
    assign issueData    = issueData_r;
    assign issueOpValid = issueOpValid_r;

    // Per-entry status, bus snoop hits and the request vector export
    always_comb begin
        for (int i = 0; i < Entries; i++) begin
            pend_s[i]       = {3{entries_r[i].busy}} & entries_r[i].used & ~entries_r[i].captured;
            freeVec_s[i]    = ~entries_r[i].busy;
            readyVec_s[i]   = entries_r[i].busy & (&entries_r[i].captured);
            reqGIdx[i]      = entries_r[i].gIdx;
            reqGIdxType[i]  = entries_r[i].gType;
            reqGIdxValid[i] = pend_s[i];
            reqMaster[i]    = |pend_s[i];
            for (int k = 0; k < 3; k++) begin
                capHit_s[i][k] = pend_s[i][k] &
                    busHit(RFBusValid, RFBusTag, entries_r[i].gIdx[k], entries_r[i].gType[k]);
            end
        end
    end

    // New entry image, with operands already on the bus written as captured
    always_comb begin
        dispEntry_s.busy  = 1'b1;
        dispEntry_s.gIdx  = dispGIdx;
        dispEntry_s.used  = dispGIdxValid;
        dispEntry_s.gType = dispGIdxType;
        dispEntry_s.captured = 3'b000;
        dispEntry_s.data     = '0;
        for (int k = 0; k < 3; k++) begin
            dispEntry_s.captured[k] = ~dispGIdxValid[k] |
                busHit(RFBusValid, RFBusTag, dispGIdx[k], dispGIdxType[k]);
            dispEntry_s.data[k] = (dispGIdxValid[k] & dispEntry_s.captured[k]) ?
                RFBusData[dispGIdxType[k]] : Vector_t'(0);
        end
    end

    // Next entry state: dispatch write, or snoop capture plus release on issue
    always_comb begin
        for (int i = 0; i < Entries; i++) begin
            if (dispFire_s && (freeIdx_s == IdxW'(i))) begin
                entriesNext_s[i] = dispEntry_s;
            end else begin
                entriesNext_s[i] = entries_r[i];
                entriesNext_s[i].busy = entries_r[i].busy &
                    ~(issueLoad_s && (readyIdx_s == IdxW'(i)));
                for (int k = 0; k < 3; k++) begin
                    entriesNext_s[i].captured[k] = entries_r[i].captured[k] | capHit_s[i][k];
                    entriesNext_s[i].data[k] = capHit_s[i][k] ?
                        RFBusData[entries_r[i].gType[k]] : entries_r[i].data[k];
                end
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Entries; i++) begin
                entries_r[i] <= '0;
                entryOp_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Entries; i++) begin
                entries_r[i] <= entriesNext_s[i];
            end
            if (dispFire_s) begin
                entryOp_r[freeIdx_s] <= dispOp;
            end
        end
    end

    // Free-entry counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            freeCount_r <= CntW'(Entries);
        end else begin
            freeCount_r <= freeCount_r + CntW'(issueLoad_s) - CntW'(dispFire_s);
        end
    end

    // Issue register, held while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issueValid_r   <= 1'b0;
            issueOp_r      <= '0;
            issueData_r    <= '0;
            issueOpValid_r <= 3'b000;
        end else if (!issueValid_r || issueReady) begin
            issueValid_r <= readyFound_s;
            if (readyFound_s) begin
                issueOp_r      <= entryOp_r[readyIdx_s];
                issueOpValid_r <= entries_r[readyIdx_s].used;
                for (int k = 0; k < 3; k++) begin
                    issueData_r[k] <= entries_r[readyIdx_s].used[k] ?
                        entries_r[readyIdx_s].data[k] : Vector_t'(0);
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_reservation_station.sv
// Randomized and directed bench for operand_reservation_station against a behavioural model.
module tb_operand_reservation_station;
    import operand_reservation_station_pkg::*;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   dispValid;
    logic                   dispReady;
    logic [31:0]            dispOp;
    GRegIdx_t [2:0]         dispGIdx;
    logic [2:0]             dispGIdxValid;
    logic [2:0]             dispGIdxType;
    logic [15:0]            reqMaster;
    GRegIdx_t [15:0][2:0]   reqGIdx;
    logic [15:0][2:0]       reqGIdxValid;
    logic [15:0][2:0]       reqGIdxType;
    logic [1:0]             RFBusValid;
    GRegIdx_t [1:0]         RFBusTag;
    Vector_t [1:0]          RFBusData;
    logic                   issueValid;
    logic                   issueReady;
    logic [31:0]            issueOp;
    Vector_t [2:0]          issueData;
    logic [2:0]             issueOpValid;
    logic [4:0]             freeCount;

    operand_reservation_station #(.Entries(16), .OpWidth(32)) dut (
        .clk(clk), .rstn(rstn),
        .dispValid(dispValid), .dispReady(dispReady), .dispOp(dispOp),
        .dispGIdx(dispGIdx), .dispGIdxValid(dispGIdxValid), .dispGIdxType(dispGIdxType),
        .reqMaster(reqMaster), .reqGIdx(reqGIdx), .reqGIdxValid(reqGIdxValid),
        .reqGIdxType(reqGIdxType),
        .RFBusValid(RFBusValid), .RFBusTag(RFBusTag), .RFBusData(RFBusData),
        .issueValid(issueValid), .issueReady(issueReady), .issueOp(issueOp),
        .issueData(issueData), .issueOpValid(issueOpValid), .freeCount(freeCount)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;
    bit checkEn = 1'b0;

    // Behavioural model: a bag of slots, each with pending-operand bits
    bit          mBusy [16];
    logic [31:0] mOp   [16];
    GRegIdx_t    mG    [16][3];
    bit   [2:0]  mUsed [16];
    bit   [2:0]  mTyp  [16];
    bit   [2:0]  mPend [16];
    logic [31:0] mDat  [16][3];
    bit          mIV;
    logic [31:0] mIOp;
    logic [31:0] mIData [3];
    bit   [2:0]  mIUsed;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int modelFree();
        int n = 0;
        for (int i = 0; i < 16; i++) if (!mBusy[i]) n++;
        return n;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mBusy[i] = 1'b0; mPend[i] = 3'b000; mUsed[i] = 3'b000;
        end
        mIV = 1'b0; mIOp = 32'h0; mIUsed = 3'b000;
        for (int k = 0; k < 3; k++) mIData[k] = 32'h0;
    endtask

    function automatic bit onBus(input GRegIdx_t g, input bit t);
        return RFBusValid[t] && (RFBusTag[t] == g);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic modelStep();
        int fIdx = -1;
        int rIdx = -1;
        bit fire;
        for (int i = 0; i < 16; i++) begin
            if (!mBusy[i]) begin
                if (fIdx < 0) fIdx = i;
            end else if (rIdx < 0 && mPend[i] == 3'b000) begin
                rIdx = i;
            end
        end
        fire = dispValid && (fIdx >= 0);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (mBusy[i] && mPend[i][k] && onBus(mG[i][k], mTyp[i][k])) begin
                    mDat[i][k] = RFBusData[mTyp[i][k]];
                    mPend[i][k] = 1'b0;
                end
            end
        end
        if (!mIV || issueReady) begin
            if (rIdx >= 0) begin
                mIV = 1'b1; mIOp = mOp[rIdx]; mIUsed = mUsed[rIdx];
                for (int k = 0; k < 3; k++) mIData[k] = mUsed[rIdx][k] ? mDat[rIdx][k] : 32'h0;
                mBusy[rIdx] = 1'b0;
            end else begin
                mIV = 1'b0;
            end
        end
        if (fire) begin
            mBusy[fIdx] = 1'b1; mOp[fIdx] = dispOp;
            mUsed[fIdx] = dispGIdxValid; mTyp[fIdx] = dispGIdxType; mPend[fIdx] = dispGIdxValid;
            for (int k = 0; k < 3; k++) begin
                mG[fIdx][k] = dispGIdx[k];
                mDat[fIdx][k] = 32'h0;
                if (dispGIdxValid[k] && onBus(dispGIdx[k], dispGIdxType[k])) begin
                    mDat[fIdx][k] = RFBusData[dispGIdxType[k]];
                    mPend[fIdx][k] = 1'b0;
                end
            end
        end
    endtask

    // Compare DUT outputs with the model every cycle
    always @(negedge clk) begin
        if (checkEn) begin
            logic [47:0] eRV;
            logic [15:0] eRM;
            logic [20:0] aF, eF;
            for (int i = 0; i < 16; i++) begin
                eRM[i] = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    eRV[i*3+k] = mBusy[i] && mPend[i][k];
                    eRM[i] = eRM[i] | eRV[i*3+k];
                end
            end
            chk("dispReady", dispReady, modelFree() != 0);
            chk("freeCount", freeCount, modelFree());
            chk("reqGIdxValid", reqGIdxValid, eRV);
            chk("reqMaster", reqMaster, eRM);
            chk("issueValid", issueValid, mIV);
            if (mIV) begin
                chk("issueOp", issueOp, mIOp);
                chk("issueOpValid", issueOpValid, mIUsed);
                chk("issueData", issueData, {mIData[2], mIData[1], mIData[0]});
            end
            for (int i = 0; i < 16; i++) begin
                if (mBusy[i]) begin
                    aF = '0; eF = '0;
                    for (int k = 0; k < 3; k++) begin
                        if (mUsed[i][k]) begin
                            aF[k*7 +: 7] = {reqGIdxType[i][k], reqGIdx[i][k]};
                            eF[k*7 +: 7] = {mTyp[i][k], mG[i][k]};
                        end
                    end
                    chk("reqFields", aF, eF);
                end
            end
        end
    end

    task automatic idle();
        dispValid = 1'b0; dispOp = 32'h0; dispGIdx = '0;
        dispGIdxValid = 3'b000; dispGIdxType = 3'b000;
        RFBusValid = 2'b00; RFBusTag = '0; RFBusData = '0;
    endtask

    task automatic cyc();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; issueReady = 1'b1;
        idle();
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dispReady", dispReady, 1'b1);
        chk("rst_freeCount", freeCount, 5'd16);
        chk("rst_issueValid", issueValid, 1'b0);
        chk("rst_reqMaster", reqMaster, 16'h0);
        rstn = 1'b1;
        checkEn = 1'b1;

        // No-operand instruction issues after the second edge
        dispValid = 1'b1; dispOp = 32'hA5;
        cyc();
        idle();
        chk("a5_free15", freeCount, 5'd15);
        cyc();
        chk("a5_valid", issueValid, 1'b1);
        chk("a5_op", issueOp, 32'hA5);
        chk("a5_opv", issueOpValid, 3'b000);
        chk("a5_free16", freeCount, 5'd16);

        // Two operands on different collectors, wrong-bus beat ignored
        dispValid = 1'b1; dispOp = 32'h77;
        dispGIdx[0] = 6'd3; dispGIdx[1] = 6'd7; dispGIdxValid = 3'b011; dispGIdxType = 3'b010;
        cyc();
        idle();
        chk("two_master", reqMaster[0], 1'b1);
        chk("two_rv", reqGIdxValid[0], 3'b011);
        RFBusValid = 2'b01; RFBusTag[0] = 6'd7; RFBusData[0] = 32'hDEAD0000;
        cyc();
        idle();
        chk("wrongbus_rv", reqGIdxValid[0], 3'b011);
        RFBusValid = 2'b01; RFBusTag[0] = 6'd3; RFBusData[0] = 32'h11111111;
        cyc();
        idle();
        chk("bus0_rv", reqGIdxValid[0], 3'b010);
        RFBusValid = 2'b10; RFBusTag[1] = 6'd7; RFBusData[1] = 32'h22222222;
        cyc();
        idle();
        chk("bus1_master", reqMaster[0], 1'b0);
        cyc();
        chk("two_valid", issueValid, 1'b1);
        chk("two_data", issueData, {32'h0, 32'h22222222, 32'h11111111});

        // Dispatch bypass: operand on the bus in the dispatch cycle
        dispValid = 1'b1; dispOp = 32'h55; dispGIdx[0] = 6'd5; dispGIdxValid = 3'b001;
        RFBusValid = 2'b01; RFBusTag[0] = 6'd5; RFBusData[0] = 32'h00000055;
        cyc();
        idle();
        chk("byp_master", reqMaster, 16'h0);
        cyc();
        chk("byp_valid", issueValid, 1'b1);
        chk("byp_data", issueData, {32'h0, 32'h0, 32'h55});

        // Fill, then free exactly one entry with a single issueReady pulse
        issueReady = 1'b0;
        dispValid = 1'b1; dispGIdxValid = 3'b000;
        for (int n = 0; n < 40 && dispReady; n++) begin
            dispOp = 32'h100 + n;
            cyc();
        end
        chk("full_ready", dispReady, 1'b0);
        chk("full_count", freeCount, 5'd0);
        issueReady = 1'b1;
        cyc();
        issueReady = 1'b0;
        chk("pulse_count", freeCount, 5'd1);
        chk("pulse_ready", dispReady, 1'b1);
        cyc();
        chk("refill_count", freeCount, 5'd0);
        idle();
        issueReady = 1'b1;
        for (int n = 0; n < 60 && (freeCount != 5'd16 || issueValid); n++) cyc();
        chk("drain", {issueValid, freeCount}, {1'b0, 5'd16});

        // Reset in the middle of work
        issueReady = 1'b0;
        dispValid = 1'b1; dispOp = 32'h9;
        cyc();
        dispGIdx[0] = 6'd9; dispGIdxValid = 3'b001;
        repeat (4) cyc();
        idle();
        cyc();
        chk("pre_rst_valid", issueValid, 1'b1);
        chk("pre_rst_free", freeCount, 5'd12);
        checkEn = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("arst_valid", issueValid, 1'b0);
        chk("arst_issue", {issueOp, issueOpValid, issueData}, 131'h0);
        chk("arst_free", freeCount, 5'd16);
        chk("arst_master", reqMaster, 16'h0);
        chk("arst_ready", dispReady, 1'b1);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        #1 rstn = 1'b1;
        RFBusValid = 2'b01; RFBusTag[0] = 6'd9; RFBusData[0] = 32'hBAD;
        checkEn = 1'b1;
        cyc();
        idle();
        chk("post_rst_master", reqMaster, 16'h0);
        cyc();
        chk("post_rst_valid", issueValid, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            dispValid = ($urandom_range(0, 1) == 1);
            dispOp = $urandom;
            for (int k = 0; k < 3; k++) dispGIdx[k] = GRegIdx_t'($urandom_range(0, 7));
            dispGIdxValid = 3'($urandom_range(0, 7));
            dispGIdxType  = 3'($urandom_range(0, 7));
            RFBusValid = 2'($urandom_range(0, 3));
            for (int b = 0; b < 2; b++) begin
                RFBusTag[b]  = GRegIdx_t'($urandom_range(0, 7));
                RFBusData[b] = $urandom;
            end
            issueReady = ((n % 300) < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle();
        issueReady = 1'b1;
        repeat (5) cyc();
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
